// File: rtl/gsim_host.sv
// Host-side driver for the Gauss-Seidel solver core. It streams a preloaded
// b vector to the solver, then captures the returned x vector into a result
// buffer. A watchdog ends any transaction whose solver goes silent.
// Optional feature macro: GSIM_HOST_CSUM_EN (adds the csum output).
// Ports:
//   clk, reset_n            : clock, async active-low reset
//   start                   : one-cycle pulse, accepted only in IDLE/DONE
//   cfg_we/cfg_addr/cfg_data: b buffer write port (IDLE/DONE only)
//   in_en/b_in              : b stream to solver, N back-to-back words
//   out_valid/x_out         : x stream from solver, gaps allowed
//   rd_addr/rd_data         : result buffer read, 1-cycle registered
//   busy/done/timeout_err   : status; timeout_err meaningful while done=1
//   csum (optional)         : running sum of x words accepted this transaction
module gsim_host #(
  parameter int N       = 16,
  parameter int B_W     = 16,
  parameter int X_W     = 32,
  parameter int TIMEOUT = 4095
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 cfg_we,
  input  logic [$clog2(N)-1:0] cfg_addr,
  input  logic [B_W-1:0]       cfg_data,
  output logic                 in_en,
  output logic [B_W-1:0]       b_in,
  input  logic                 out_valid,
  input  logic [X_W-1:0]       x_out,
  input  logic [$clog2(N)-1:0] rd_addr,
  output logic [X_W-1:0]       rd_data,
  output logic                 busy,
  output logic                 done,
`ifdef GSIM_HOST_CSUM_EN
  output logic [X_W-1:0]       csum,
`endif
  output logic                 timeout_err
);

  localparam int AW  = $clog2(N);
  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_COLLECT,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [AW-1:0]   r_tx_cnt;
  logic [AW-1:0]   r_rx_cnt;
  logic [WDW-1:0]  r_wdog;
  logic [B_W-1:0]  r_b_buf [N];
  logic [X_W-1:0]  r_x_buf [N];

  logic            w_idle_or_done;
  logic            w_start_acc;
  logic            w_cfg_wr;
  logic            w_x_wr;
  logic            w_wdog_expired;

  assign w_idle_or_done = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_start_acc    = start && w_idle_or_done;
  assign w_cfg_wr       = cfg_we && w_idle_or_done;
  // rx_cnt is 0 throughout WAIT, so one write port serves WAIT and COLLECT.
  assign w_x_wr         = out_valid && ((r_state == S_WAIT) || (r_state == S_COLLECT));
  // Counter shows cycles already spent; the next edge is the TIMEOUT-th one.
  assign w_wdog_expired = (r_wdog == WDW'(TIMEOUT - 1));

  // Control FSM; all status outputs are registered here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_tx_cnt    <= '0;
      r_rx_cnt    <= '0;
      r_wdog      <= '0;
      in_en       <= 1'b0;
      b_in        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state     <= S_SEND;
            r_tx_cnt    <= '0;
            r_rx_cnt    <= '0;
            r_wdog      <= '0;
            in_en       <= 1'b1;
            b_in        <= r_b_buf[0];
            busy        <= 1'b1;
            done        <= 1'b0;
            timeout_err <= 1'b0;
          end
        end
        S_SEND: begin
          if (r_tx_cnt == AW'(N - 1)) begin
            r_state <= S_WAIT;
            r_wdog  <= '0;
            in_en   <= 1'b0;
            b_in    <= '0;
          end else begin
            // Prefetch the next entry so b_in tracks tx_cnt cycle for cycle.
            r_tx_cnt <= r_tx_cnt + AW'(1);
            b_in     <= r_b_buf[r_tx_cnt + AW'(1)];
          end
        end
        S_WAIT: begin
          if (out_valid) begin
            r_state  <= S_COLLECT;
            r_rx_cnt <= AW'(1);
            r_wdog   <= '0;
          end else if (w_wdog_expired) begin
            r_state     <= S_DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            timeout_err <= 1'b1;
          end else begin
            r_wdog <= r_wdog + WDW'(1);
          end
        end
        S_COLLECT: begin
          if (out_valid) begin
            r_wdog <= '0;
            if (r_rx_cnt == AW'(N - 1)) begin
              r_state <= S_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              r_rx_cnt <= r_rx_cnt + AW'(1);
            end
          end else if (w_wdog_expired) begin
            r_state     <= S_DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            timeout_err <= 1'b1;
          end else begin
            r_wdog <= r_wdog + WDW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          in_en   <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

  // Buffer storage; contents survive reset by design.
  always_ff @(posedge clk) begin
    if (w_cfg_wr) begin
      r_b_buf[cfg_addr] <= cfg_data;
    end
    if (w_x_wr) begin
      r_x_buf[r_rx_cnt] <= x_out;
    end
  end

  // Registered read; a same-cycle write to the entry returns the old value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= r_x_buf[rd_addr];
    end
  end

`ifdef GSIM_HOST_CSUM_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csum <= '0;
    end else if (w_start_acc) begin
      csum <= '0;
    end else if (w_x_wr) begin
      csum <= csum + x_out;
    end
  end
`endif

endmodule
